frame_buffer_read_arbiter: RTL and testbench

Arbitrates the single read port of the frame-buffer RAM between two requesters: VGA scan-out, which issues raster addresses, and the effects (VFX) engine, which issues random-access pixel reads. VGA has priority. A starvation guard forces an occasional effects grant; VGA tolerates the resulting stall through its `vga_ready` back-pressure. Read data returns on a shared bus, with a per-requester valid strobe aligned to the RAM read latency.

---
 rtl/frame_buffer_read_arbiter.sv | 151 +++++++++++++++
 tb/tb_frame_buffer_read_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_read_arbiter.sv
// frame_buffer_read_arbiter
//   Shares the frame-buffer RAM read port between VGA scan-out and the
//   effects engine. VGA normally wins. After STARVE_LIMIT consecutive
//   denied effects cycles, the effects engine gets one forced grant.
//   Read data comes back on a shared registered bus. A per-requester
//   valid strobe is aligned to the RAM read latency.
// Ports
//   clk_25_vga, reset_n             : clock, async active-low reset
//   flush                           : drop in-flight returns, clear starvation state
//   vga_req/vga_addr/vga_gnt        : VGA request, address, grant
//   vga_rvalid                      : rd_data belongs to VGA
//   fx_req/fx_addr/fx_gnt           : effects request, address, grant
//   fx_rvalid                       : rd_data belongs to effects
//   ram_rdaddress/ram_rden          : RAM read address and enable
//   ram_rddata                      : RAM read data
//   rd_data                         : registered copy of ram_rddata
//   starve_events                   : saturating count of forced effects grants
module frame_buffer_read_arbiter #(
   parameter int ADDR_W       = 17,
   parameter int DATA_W       = 12,
   parameter int RD_LAT       = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk_25_vga,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   input  logic              fx_req,
   input  logic [ADDR_W-1:0] fx_addr,
   output logic              fx_gnt,
   output logic              fx_rvalid,
   output logic [ADDR_W-1:0] ram_rdaddress,
   output logic              ram_rden,
   input  logic [DATA_W-1:0] ram_rddata,
   output logic [DATA_W-1:0] rd_data,
   output logic [15:0]       starve_events
);

   typedef enum logic {PRIO_VGA = 1'b0, PRIO_FX = 1'b1} state_t;

   localparam logic [8:0] LIMIT = 9'(STARVE_LIMIT);

   state_t              state, state_nxt;
   logic [7:0]          starve_cnt, starve_cnt_nxt;
   logic [8:0]          cnt_inc;
   logic [ADDR_W-1:0]   last_addr;
   logic [RD_LAT-1:0]   tag_vld;
   logic [RD_LAT-1:0]   tag_fx;

   // state register; flush pulls arbitration back to VGA priority
   always_ff @(posedge clk_25_vga or negedge reset_n) begin
      if (!reset_n) begin
         state      <= PRIO_VGA;
         starve_cnt <= '0;
      end else if (flush) begin
         state      <= PRIO_VGA;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
      end
   end

   // next state: count denied effects cycles. The transition fires on the
   // edge where the count would reach the limit, so the forced grant comes
   // right after STARVE_LIMIT denials.
   always_comb begin
      state_nxt      = state;
      starve_cnt_nxt = '0;
      cnt_inc        = {1'b0, starve_cnt} + 9'd1;
      if (state == PRIO_VGA) begin
         if (fx_req && !fx_gnt) begin
            if (cnt_inc == LIMIT) begin
               state_nxt = PRIO_FX;
            end else begin
               starve_cnt_nxt = cnt_inc[7:0];
            end
         end
      end else begin
         // One cycle only. Either effects is granted, or it withdrew.
         state_nxt = PRIO_VGA;
      end
   end

   // output: grants, forced low while reset is asserted
   always_comb begin
      vga_gnt = 1'b0;
      fx_gnt  = 1'b0;
      if (reset_n) begin
         if (state == PRIO_VGA) begin
            vga_gnt = vga_req;
            fx_gnt  = fx_req && !vga_req;
         end else begin
            fx_gnt  = fx_req;
            vga_gnt = vga_req && !fx_req;
         end
      end
   end

   assign ram_rden      = vga_gnt | fx_gnt;
   assign ram_rdaddress = fx_gnt ? fx_addr : (vga_gnt ? vga_addr : last_addr);

   always_ff @(posedge clk_25_vga or negedge reset_n) begin
      if (!reset_n) begin
         last_addr     <= '0;
         starve_events <= '0;
      end else begin
         if (ram_rden)
            last_addr <= ram_rdaddress;
         if (fx_gnt && state == PRIO_FX && starve_events != 16'hFFFF)
            starve_events <= starve_events + 16'd1;
      end
   end

   // Return tags ride alongside the RAM pipeline. The rvalid flops line up
   // with rd_data, which adds one register after the RAM.
   always_ff @(posedge clk_25_vga or negedge reset_n) begin
      if (!reset_n) begin
         tag_vld    <= '0;
         tag_fx     <= '0;
         vga_rvalid <= 1'b0;
         fx_rvalid  <= 1'b0;
      end else if (flush) begin
         tag_vld    <= '0;
         tag_fx     <= '0;
         vga_rvalid <= 1'b0;
         fx_rvalid  <= 1'b0;
      end else begin
         tag_vld[0] <= ram_rden;
         tag_fx[0]  <= fx_gnt;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_fx[i]  <= tag_fx[i-1];
         end
         vga_rvalid <= tag_vld[RD_LAT-1] && !tag_fx[RD_LAT-1];
         fx_rvalid  <= tag_vld[RD_LAT-1] &&  tag_fx[RD_LAT-1];
      end
   end

   // flush leaves the data register alone; only reset clears it
   always_ff @(posedge clk_25_vga or negedge reset_n) begin
      if (!reset_n)
         rd_data <= '0;
      else
         rd_data <= ram_rddata;
   end

endmodule

// File: tb/tb_frame_buffer_read_arbiter.sv
// tb_frame_buffer_read_arbiter
//   Directed phases with randomized traffic. Each cycle is checked against
//   a reference model that tracks the grant rules, the starvation count and
//   a scoreboard of expected returns.
// Ports: none (top-level bench).
module tb_frame_buffer_read_arbiter;

   localparam int AW   = 17;
   localparam int DW   = 12;
   localparam int LAT  = 2;
   localparam int LIM  = 8;
   localparam int NPIX = 76800;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush = 1'b0;
   logic          vga_req = 1'b0, fx_req = 1'b0;
   logic [AW-1:0] vga_addr = '0, fx_addr = '0;
   logic          vga_gnt, fx_gnt, vga_rvalid, fx_rvalid, ram_rden;
   logic [AW-1:0] ram_rdaddress;
   logic [DW-1:0] ram_rddata = '0, ram_p1 = '0, rd_data;
   logic [15:0]   starve_events;

   frame_buffer_read_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .STARVE_LIMIT(LIM)
   ) dut (
      .clk_25_vga(clk), .reset_n(reset_n), .flush(flush),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
      .fx_req(fx_req), .fx_addr(fx_addr), .fx_gnt(fx_gnt), .fx_rvalid(fx_rvalid),
      .ram_rdaddress(ram_rdaddress), .ram_rden(ram_rden), .ram_rddata(ram_rddata),
      .rd_data(rd_data), .starve_events(starve_events)
   );

   always #20 clk = ~clk;

   // RAM contents as a fixed function of the address
   function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
      logic [AW-1:0] t;
      t = a * 17'd13 + (a >> 4);
      return t[DW-1:0] ^ 12'h5A3;
   endfunction

   // two-cycle RAM read model
   always @(posedge clk) begin
      ram_p1     <= mem(ram_rdaddress);
      ram_rddata <= ram_p1;
   end

   int errs = 0, checks = 0, cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // reference model
   typedef struct { int due; bit fx; logic [DW-1:0] d; } ret_t;
   ret_t          q[$];
   bit            m_fx = 0;       // next cycle is the forced effects slot
   int            m_den = 0;      // consecutive denied effects cycles
   int            m_ev = 0;
   logic [AW-1:0] m_last = '0;
   bit            e_vg, e_fg;
   logic [AW-1:0] e_addr;
   bit            vinc = 1;       // VGA raster increment vs random address
   bit            track_run = 0;
   bit            run_seen = 0;
   int            vrun = 0;

   task automatic model_reset();
      q.delete();
      m_fx = 0; m_den = 0; m_ev = 0; m_last = '0;
   endtask

   task automatic check_cycle();
      bit ev_v, ev_f;
      logic [DW-1:0] ed;
      e_vg   = m_fx ? (vga_req && !fx_req) : vga_req;
      e_fg   = m_fx ? fx_req : (fx_req && !vga_req);
      e_addr = e_fg ? fx_addr : (e_vg ? vga_addr : m_last);
      chk("vga_gnt", vga_gnt, e_vg);
      chk("fx_gnt", fx_gnt, e_fg);
      chk("ram_rden", ram_rden, e_vg | e_fg);
      chk("ram_rdaddress", ram_rdaddress, e_addr);
      ev_v = 0; ev_f = 0; ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         ev_v = !q[0].fx; ev_f = q[0].fx; ed = q[0].d;
         void'(q.pop_front());
      end
      chk("vga_rvalid", vga_rvalid, ev_v);
      chk("fx_rvalid", fx_rvalid, ev_f);
      if (ev_v || ev_f) chk("rd_data", rd_data, ed);
      chk("starve_events", starve_events, m_ev);
      if (track_run) begin
         if (e_fg) begin
            if (run_seen) chk("vga_run_len", vrun, LIM);
            vrun = 0; run_seen = 1;
         end else if (e_vg) vrun++;
      end
   endtask

   task automatic model_update();
      if (e_fg && m_fx && m_ev < 65535) m_ev++;
      if (e_vg || e_fg) m_last = e_addr;
      if (flush) begin
         q.delete();
         m_fx = 0; m_den = 0;
      end else begin
         if (e_vg || e_fg) q.push_back('{cyc + LAT + 1, e_fg, mem(e_addr)});
         if (m_fx) begin
            m_fx = 0; m_den = 0;
         end else if (fx_req && !e_fg) begin
            m_den++;
            if (m_den == LIM) begin m_fx = 1; m_den = 0; end
         end else m_den = 0;
      end
   endtask

   // one clock: check at negedge, advance model, then new addresses after grants
   task automatic step();
      @(negedge clk);
      check_cycle();
      model_update();
      @(posedge clk); #1;
      cyc++;
      if (e_vg) vga_addr = vinc ? ((vga_addr == AW'(NPIX-1)) ? '0 : vga_addr + 1'b1)
                                : AW'($urandom_range(0, NPIX-1));
      if (e_fg) fx_addr = AW'($urandom_range(0, NPIX-1));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vga_gnt"}, vga_gnt, 0);
      chk({tag, "_fx_gnt"}, fx_gnt, 0);
      chk({tag, "_vga_rvalid"}, vga_rvalid, 0);
      chk({tag, "_fx_rvalid"}, fx_rvalid, 0);
      chk({tag, "_ram_rden"}, ram_rden, 0);
      chk({tag, "_ram_rdaddress"}, ram_rdaddress, 0);
      chk({tag, "_rd_data"}, rd_data, 0);
      chk({tag, "_starve_events"}, starve_events, 0);
   endtask

   int saved_ev;

   initial begin
      // reset state, with both requests high so the grant gating is visible
      vga_req = 1; fx_req = 1;
      #10;
      chk_all_zero("reset");
      @(posedge clk); #1;
      reset_n = 1;
      model_reset();
      cyc = 0;

      // 1: VGA only, raster addresses, including the wrap at the last pixel
      fx_req = 0; vga_req = 1; vinc = 1;
      for (int i = 0; i < 30; i++) step();
      vga_addr = AW'(NPIX - 5);
      for (int i = 0; i < 12; i++) step();
      vga_req = 0;
      for (int i = 0; i < 5; i++) step();

      // 2: effects only, random pulses
      for (int i = 0; i < 40; i++) begin
         fx_req = 1'($urandom_range(0, 1));
         step();
      end
      fx_req = 0;
      for (int i = 0; i < 5; i++) step();

      // 3: continuous contention, expect 8 VGA grants between effects grants
      vga_req = 1; fx_req = 1; track_run = 1; run_seen = 0; vrun = 0;
      for (int i = 0; i < 60; i++) step();
      track_run = 0;

      // 4: effects withdraws in the forced slot
      begin
         int n = 0;
         while (!m_fx && n < 20) begin step(); n++; end
         if (!m_fx) begin
            checks++; errs++;
            $error("FAIL reach_prio_fx observed=timeout expected=forced slot");
         end
      end
      saved_ev = starve_events;
      fx_req = 0;
      step();
      chk("withdraw_starve_events", starve_events, saved_ev);
      fx_req = 1;
      for (int i = 0; i < 12; i++) step();

      // 5: flush mid-contention, with returns in flight and a grant in the flush cycle
      fx_req = 0;
      for (int i = 0; i < 4; i++) step();
      fx_req = 1;
      for (int i = 0; i < 5; i++) step();
      flush = 1;
      step();
      flush = 0;
      for (int i = 0; i < 20; i++) step();

      // 6: asynchronous reset between edges during contention
      #5;
      reset_n = 0;
      #1;
      chk_all_zero("async_reset");
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1;
      model_reset();
      for (int i = 0; i < 20; i++) step();

      // 7: random mix with occasional flush
      vinc = 0;
      for (int i = 0; i < 300; i++) begin
         vga_req = ($urandom_range(0, 3) != 0);
         fx_req  = ($urandom_range(0, 2) == 0);
         flush   = ($urandom_range(0, 39) == 0);
         step();
      end
      flush = 0; vga_req = 0; fx_req = 0;
      for (int i = 0; i < 6; i++) step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
